icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped instruction cache: 2^INDEX_WIDTH lines of four 32-bit words, one-word memory refill port.
// Optional macro ICACHE_EARLY_RESTART_EN answers a miss as soon as the requested word returns.
module icache #(
  parameter int INDEX_WIDTH = 5,
  parameter int LINE_WORDS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        pc_send_enable,
  input  logic [31:0] pc_to_ic,
  output logic        inst_get_ready,
  output logic [31:0] inst_from_ic,
  input  logic        jump_flag,
  output logic        mem_req_enable,
  output logic [31:0] mem_addr,
  input  logic        mem_data_ready,
  input  logic [31:0] mem_data
);
  localparam int NUM_LINES = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = 28 - INDEX_WIDTH;
  localparam int LINE_BITS = 32 * LINE_WORDS;

  typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

  state_t                 r_state;
  logic [NUM_LINES-1:0]   r_valid;
  logic [TAG_WIDTH-1:0]   r_tag [NUM_LINES];
  logic [LINE_BITS-1:0]   r_data [NUM_LINES];
  logic [27:0]            r_req_line;
  logic [1:0]             r_req_off;
  logic [1:0]             r_word_cnt;
  logic [LINE_BITS-33:0]  r_line_buf;
  logic                   r_guard;
  logic                   r_cancel;
  logic                   r_inst_get_ready;
  logic [31:0]            r_inst_from_ic;
  logic                   r_mem_req_enable;
  logic [31:0]            r_mem_addr;

  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_WIDTH-1:0]   w_tag;
  logic [1:0]             w_off;
  logic                   w_req;
  logic                   w_hit;
  logic [31:0]            w_hit_word;
  logic                   w_accept;
  logic                   w_last;
  logic [INDEX_WIDTH-1:0] w_fill_idx;
  logic [TAG_WIDTH-1:0]   w_fill_tag;
  logic [LINE_BITS-1:0]   w_line;
  logic                   w_fill_pulse;
  logic [31:0]            w_fill_word;
  logic                   w_unused;

  assign w_idx      = pc_to_ic[3+INDEX_WIDTH:4];
  assign w_tag      = pc_to_ic[31:4+INDEX_WIDTH];
  assign w_off      = pc_to_ic[3:2];
  assign w_unused   = ^pc_to_ic[1:0];
  assign w_req      = pc_send_enable && !r_guard && !jump_flag;
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_hit_word = r_data[w_idx][{w_off, 5'b00000} +: 32];
  assign w_accept   = (r_state == REFILL) && r_mem_req_enable && mem_data_ready;
  assign w_last     = w_accept && (r_word_cnt == 2'd3);
  assign w_fill_idx = r_req_line[INDEX_WIDTH-1:0];
  assign w_fill_tag = r_req_line[27:INDEX_WIDTH];
  // The last word is never buffered; it completes the line straight from the bus.
  assign w_line     = {mem_data, r_line_buf};

`ifdef ICACHE_EARLY_RESTART_EN
  assign w_fill_pulse = w_accept && (r_word_cnt == r_req_off) && !r_cancel && !jump_flag;
  assign w_fill_word  = mem_data;
`else
  assign w_fill_pulse = w_last && !r_cancel && !jump_flag;
  assign w_fill_word  = w_line[{r_req_off, 5'b00000} +: 32];
`endif

  // Tag/data arrays: written only when a refill completes; valid bits gate every read.
  always_ff @(posedge clk) begin
    if (!rst && rdy && w_last) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= w_line;
    end
  end

  // Control FSM, valid bits and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_valid          <= '0;
      r_req_line       <= 28'd0;
      r_req_off        <= 2'd0;
      r_word_cnt       <= 2'd0;
      r_line_buf       <= '0;
      r_guard          <= 1'b0;
      r_cancel         <= 1'b0;
      r_inst_get_ready <= 1'b0;
      r_inst_from_ic   <= 32'd0;
      r_mem_req_enable <= 1'b0;
      r_mem_addr       <= 32'd0;
    end else if (!rdy) begin
      r_inst_get_ready <= 1'b0;
    end else begin
      r_inst_get_ready <= 1'b0;
      r_guard          <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req && w_hit) begin
            r_inst_get_ready <= 1'b1;
            r_inst_from_ic   <= w_hit_word;
            r_guard          <= 1'b1;
          end else if (w_req) begin
            r_state          <= REFILL;
            r_req_line       <= pc_to_ic[31:4];
            r_req_off        <= w_off;
            r_word_cnt       <= 2'd0;
            r_cancel         <= 1'b0;
            r_mem_req_enable <= 1'b1;
            r_mem_addr       <= {pc_to_ic[31:4], 4'b0000};
          end
        end
        REFILL: begin
          if (jump_flag) begin
            r_cancel <= 1'b1;
          end
          if (w_fill_pulse) begin
            r_inst_get_ready <= 1'b1;
            r_inst_from_ic   <= w_fill_word;
            r_guard          <= 1'b1;
          end
          if (w_last) begin
            r_mem_req_enable   <= 1'b0;
            r_state            <= IDLE;
            r_valid[w_fill_idx] <= 1'b1;
          end else if (w_accept) begin
            // Drop the request for one cycle, then ask for the next word.
            r_mem_req_enable <= 1'b0;
            r_line_buf[{r_word_cnt, 5'b00000} +: 32] <= mem_data;
            r_word_cnt       <= r_word_cnt + 2'd1;
            r_mem_addr       <= {r_req_line, r_word_cnt + 2'd1, 2'b00};
          end else if (!r_mem_req_enable) begin
            r_mem_req_enable <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign inst_get_ready = r_inst_get_ready;
  assign inst_from_ic   = r_inst_from_ic;
  assign mem_req_enable = r_mem_req_enable;
  assign mem_addr       = r_mem_addr;

endmodule
